// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer sharing one memory port between fetch and data access.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module multicycle_control #(
    parameter int OPC_W  = 11,
    parameter int BROP_W = 3,
    parameter logic [BROP_W-1:0] BCOND_OP_NONE   = BROP_W'(0),
    parameter logic [BROP_W-1:0] BCOND_OP_ZERO   = BROP_W'(1),
    parameter logic [BROP_W-1:0] BCOND_OP_BRANCH = BROP_W'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              IorD,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              PCSrc,
    output logic              Reg2Loc,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic [1:0]        ALUOp,
    output logic [BROP_W-1:0] BranchOp,
    output logic [1:0]        MemtoReg,
    output logic              illegal
`ifdef MC_PERF_CNT_EN
   ,output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_LDUR  = 3'd0,
        CL_STUR  = 3'd1,
        CL_RTYPE = 3'd2,
        CL_CBZ   = 3'd3,
        CL_B     = 3'd4,
        CL_ILL   = 3'd5
    } cls_t;

    state_t r_state;
    state_t w_state_nxt;
    cls_t   r_cls;
    cls_t   w_cls;

    always_comb begin
        w_cls = CL_ILL;
        if (opcode == OPC_W'(11'h7C2))
            w_cls = CL_LDUR;
        else if (opcode == OPC_W'(11'h7C0))
            w_cls = CL_STUR;
        else if (opcode == OPC_W'(11'h458) || opcode == OPC_W'(11'h658) ||
                 opcode == OPC_W'(11'h450) || opcode == OPC_W'(11'h550))
            w_cls = CL_RTYPE;
        else if (opcode[10:3] == 8'hB4)
            w_cls = CL_CBZ;
        else if (opcode[10:5] == 6'h05)
            w_cls = CL_B;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cls   <= CL_ILL;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DECODE)
                r_cls <= w_cls;
        end
    end

    // zero never reaches this block: branch outcome only gates PCWrite
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FETCH:  if (mem_ready) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = (w_cls == CL_ILL) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (r_cls == CL_LDUR || r_cls == CL_STUR)
                    w_state_nxt = S_MEM;
                else if (r_cls == CL_RTYPE)
                    w_state_nxt = S_WB;
                else
                    w_state_nxt = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready)
                    w_state_nxt = (r_cls == CL_STUR) ? S_FETCH : S_WB;
            end
            S_WB:     w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Reg2Loc  = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        BranchOp = BCOND_OP_NONE;
        MemtoReg = 2'b00;
        illegal  = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    Reg2Loc = (w_cls == CL_STUR) || (w_cls == CL_CBZ);
                    illegal = (w_cls == CL_ILL);
                end
                S_EXEC: begin
                    unique case (r_cls)
                        CL_LDUR, CL_STUR: ALUSrc = 1'b1;
                        CL_RTYPE:         ALUOp  = 2'b10;
                        CL_CBZ: begin
                            ALUOp    = 2'b01;
                            BranchOp = BCOND_OP_ZERO;
                            PCSrc    = 1'b1;
                            PCWrite  = zero;
                        end
                        CL_B: begin
                            BranchOp = BCOND_OP_BRANCH;
                            PCSrc    = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    mem_we  = (r_cls == CL_STUR);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (r_cls == CL_LDUR) ? 2'b01 : 2'b00;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic w_retire;

    // Last cycle of each legal instruction; ILL never leaves DECODE for EXEC
    assign w_retire = ((r_state == S_EXEC) && (r_cls == CL_CBZ || r_cls == CL_B)) ||
                      ((r_state == S_MEM) && (r_cls == CL_STUR) && mem_ready) ||
                      (r_state == S_WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles  <= 32'd0;
            perf_retired <= 32'd0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (w_retire)
                perf_retired <= perf_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; perf counter checks compile in with MC_PERF_CNT_EN.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite, ALUSrc, illegal;
    logic [1:0]  ALUOp, MemtoReg;
    logic [2:0]  BranchOp;
`ifdef MC_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .BranchOp(BranchOp), .MemtoReg(MemtoReg),
        .illegal(illegal)
`ifdef MC_PERF_CNT_EN
       ,.perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite, ALUSrc, ALUOp, BranchOp, MemtoReg, illegal}
    logic [16:0] w_out;
    assign w_out = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc, RegWrite,
                    ALUSrc, ALUOp, BranchOp, MemtoReg, illegal};

    localparam logic [16:0] ZERO_O  = 17'd0;
    localparam logic [16:0] F_OK    = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] F_WAIT  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] D_PLAIN = 17'd0;
    localparam logic [16:0] D_R2L   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] D_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'd0,2'b00,1'b1};
    localparam logic [16:0] E_MEM   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] E_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'd0,2'b00,1'b0};
    localparam logic [16:0] E_CBZ1  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b01,3'd1,2'b00,1'b0};
    localparam logic [16:0] E_CBZ0  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'd1,2'b00,1'b0};
    localparam logic [16:0] E_B     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,3'd2,2'b00,1'b0};
    localparam logic [16:0] M_LD    = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] M_ST    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'd0,2'b00,1'b0};
    localparam logic [16:0] W_LD    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'd0,2'b01,1'b0};
    localparam logic [16:0] W_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'd0,2'b00,1'b0};

    function automatic logic [10:0] opc_of(input logic [31:0] ir);
        return ir[31:21];
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = opc_of(32'hF84402C9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (w_out !== ZERO_O) begin
                errors++;
                $display("FAIL reset cyc%0d: got %h expected %h", i, w_out, ZERO_O);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_ldur();
        logic [16:0] exp [5];
        exp = '{F_OK, D_PLAIN, E_MEM, M_LD, W_LD};
        opcode = opc_of(32'hF84402C9); zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL ldur cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back_rtype();
        logic [16:0] exp [8];
        logic [31:0] ir [2];
        exp = '{F_OK, D_PLAIN, E_R, W_R, F_OK, D_PLAIN, E_R, W_R};
        ir  = '{32'h8B09026A, 32'hCB0A028B};
        for (int i = 0; i < 8; i++) begin
            opcode = opc_of(ir[i/4]); mem_ready = 1'b1; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL rtype cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stur_wait();
        logic [16:0] exp [8];
        logic        rdy [8];
        exp = '{F_WAIT, F_OK, D_R2L, E_MEM, M_ST, M_ST, M_ST, M_ST};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = opc_of(32'hF80602CB);
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL stur cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cbz();
        logic [16:0] exp [6];
        logic        zr  [6];
        exp = '{F_OK, D_R2L, E_CBZ1, F_OK, D_R2L, E_CBZ0};
        zr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        opcode = opc_of(32'hB4FFFF6B);
        for (int i = 0; i < 6; i++) begin
            zero = zr[i]; mem_ready = 1'b1; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL cbz cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp [3];
        exp = '{F_OK, D_PLAIN, E_B};
        opcode = opc_of(32'h14000040); zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL branch cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [16:0] exp [3];
        logic        rdy [3];
        exp = '{F_OK, D_ILL, F_WAIT};
        rdy = '{1'b1, 1'b1, 1'b0};
        opcode = 11'h000;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (w_out !== exp[i]) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %h expected %h", i, w_out, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] pre  [4];
        logic        rdyp [4];
        logic [16:0] post [5];
        logic        rdyq [5];
        pre  = '{F_OK, D_R2L, E_MEM, M_ST};
        rdyp = '{1'b1, 1'b1, 1'b1, 1'b0};
        post = '{F_WAIT, F_OK, D_R2L, E_MEM, M_ST};
        rdyq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef MC_PERF_CNT_EN
        checks++;
        if (perf_retired !== 32'd7) begin
            errors++;
            $display("FAIL perf_retired_before: got %0d expected 7", perf_retired);
        end
`endif
        opcode = opc_of(32'hF80602CB);
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdyp[i]; #1;
            checks++;
            if (w_out !== pre[i]) begin
                errors++;
                $display("FAIL rstmid_pre cyc%0d: got %h expected %h", i, w_out, pre[i]);
            end
            @(posedge clk); #1;
        end
        // still in MEM: assert reset with mem_ready high, outputs must drop immediately
        rst = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (w_out !== ZERO_O) begin
                errors++;
                $display("FAIL rstmid_rst cyc%0d: got %h expected %h", i, w_out, ZERO_O);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
`ifdef MC_PERF_CNT_EN
        checks++;
        if (perf_cycles !== 32'd0 || perf_retired !== 32'd0) begin
            errors++;
            $display("FAIL perf_cleared: got cycles=%0d retired=%0d expected 0/0", perf_cycles, perf_retired);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdyq[i]; #1;
            checks++;
            if (w_out !== post[i]) begin
                errors++;
                $display("FAIL rstmid_post cyc%0d: got %h expected %h", i, w_out, post[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (w_out !== F_WAIT) begin
            errors++;
            $display("FAIL rstmid_refetch: got %h expected %h", w_out, F_WAIT);
        end
`ifdef MC_PERF_CNT_EN
        checks++;
        if (perf_cycles !== 32'd5 || perf_retired !== 32'd1) begin
            errors++;
            $display("FAIL perf_after: got cycles=%0d retired=%0d expected 5/1", perf_cycles, perf_retired);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 11'h000;
        test_reset();
        test_ldur();
        test_back_to_back_rtype();
        test_stur_wait();
        test_cbz();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
